// File: rtl/pmu_axil_scanner_if.sv
// pmu_axil_scanner_if: AXI-lite bus between the scanner (master) and the PMU register file (slave)
interface pmu_axil_scanner_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  modport master (
    output araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/pmu_axil_scanner.sv
// pmu_axil_scanner: sweeps PMU counters over AXI-lite into an index-tagged stream, optionally clearing each
module pmu_axil_scanner #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int IDX_WIDTH = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                      noc_clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [IDX_WIDTH-1:0]      first_idx_i,
  input  logic [IDX_WIDTH-1:0]      last_idx_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [AXI_DATA_WIDTH-1:0] out_data_o,
  output logic [IDX_WIDTH-1:0]      out_idx_o,
  pmu_axil_scanner_if.master        m_axi
);
  typedef enum logic [2:0] {IDLE, AR, R, OUT, AW_W, B, DONE} state_t;
  state_t state, state_nx;
  logic clr, aw_pend, w_pend, at_last, adv, aw_ok, w_ok, out_hs;
  logic [IDX_WIDTH-1:0] idx, last;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  // Address is derived from idx so AR and AW of one register always match
  assign addr    = BASE_ADDR + AXI_ADDR_WIDTH'({idx, 3'b000});
  assign at_last = idx == last;
  assign out_hs  = state == OUT && out_ready_i;
  assign aw_ok   = !aw_pend || m_axi.awready;
  assign w_ok    = !w_pend || m_axi.wready;
  assign adv     = (out_hs && !clr) || (state == B && m_axi.bvalid);
  assign busy_o      = state != IDLE;
  assign done_o      = state == DONE;
  assign out_valid_o = state == OUT;
  assign m_axi.araddr  = addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = state == AR;
  assign m_axi.rready  = state == R;
  assign m_axi.awaddr  = addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = aw_pend;
  assign m_axi.wdata   = '0;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = w_pend;
  assign m_axi.bready  = state == B;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_i) state_nx = first_idx_i > last_idx_i ? DONE : AR;
      AR:   if (m_axi.arready) state_nx = R;
      R:    if (m_axi.rvalid) state_nx = OUT;
      OUT:  if (out_ready_i) state_nx = clr ? AW_W : (at_last ? DONE : AR);
      AW_W: if (aw_ok && w_ok) state_nx = B;
      B:    if (m_axi.bvalid) state_nx = at_last ? DONE : AR;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge noc_clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge noc_clk or negedge rst) begin
    if (!rst) begin
      clr        <= 1'b0;
      idx        <= '0;
      last       <= '0;
      err_o      <= 1'b0;
      out_data_o <= '0;
      out_idx_o  <= '0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
    end else begin
      if (state == IDLE && start_i) begin
        clr   <= clear_i;
        idx   <= first_idx_i;
        last  <= last_idx_i;
        err_o <= first_idx_i > last_idx_i;
      end
      if (state == R && m_axi.rvalid) begin
        out_data_o <= m_axi.rdata;
        out_idx_o  <= idx;
        if (m_axi.rresp != 2'b00) err_o <= 1'b1;
      end
      if (state == B && m_axi.bvalid && m_axi.bresp != 2'b00) err_o <= 1'b1;
      if (adv && !at_last) idx <= idx + 1'b1;
      // AW and W rise together on entry, then each retires on its own ready
      aw_pend <= (out_hs && clr) || (aw_pend && !m_axi.awready);
      w_pend  <= (out_hs && clr) || (w_pend && !m_axi.wready);
    end
  end
endmodule

// File: tb/tb_pmu_axil_scanner.sv
// tb_pmu_axil_scanner: reactive AXI-lite slave plus scoreboard of expected stream beats and bus addresses
module tb_pmu_axil_scanner;
  logic noc_clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, clear_i = 1'b0, out_ready_i = 1'b0;
  logic [7:0] first_idx_i = '0, last_idx_i = '0;
  logic busy_o, done_o, err_o, out_valid_o;
  logic [63:0] out_data_o;
  logic [7:0] out_idx_o;
  typedef struct packed {logic [7:0] idx; logic [63:0] data;} beat_t;
  beat_t sb_q[$];
  beat_t exp_b;
  logic [63:0] ar_q[$], aw_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, hs_cyc = 0, start_cyc = 0, b_cyc = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, arv_cyc = 0, awv_cyc = 0;
  int ar_delay = 0, aw_delay = 0, w_delay = 0, ar_wait = 0, aw_wait = 0, w_wait = 0;
  int blk_idx = -1, blk_len = 0, blk_cnt = 0, slverr_idx = -1;
  int a0, w0, v0;
  logic [63:0] rd_addr = '0, held_data = '0;
  logic [7:0] held_idx = '0;

  pmu_axil_scanner_if axi ();

  pmu_axil_scanner dut (
    .noc_clk(noc_clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
    .first_idx_i(first_idx_i), .last_idx_i(last_idx_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_idx_o(out_idx_o), .m_axi(axi)
  );

  always #5 noc_clk = ~noc_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Slave and stream sink: decide readies on the falling edge; a handshake seen here completes on the next rise
  initial begin
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    forever begin
      @(negedge noc_clk);
      cyc++;
      if (!rst) begin
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        out_ready_i = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (axi.arvalid) arv_cyc++;
        if (axi.awvalid || axi.wvalid) awv_cyc++;
        axi.arready = axi.arvalid && ar_wait >= ar_delay;
        ar_wait = (axi.arvalid && !axi.arready) ? ar_wait + 1 : 0;
        if (axi.arvalid && axi.arready) begin
          ar_cnt++;
          rd_addr = axi.araddr;
          chk("ar_addr", axi.araddr, ar_q.size() != 0 ? ar_q.pop_front() : 64'hdead);
        end
        axi.rvalid = axi.rready;
        axi.rdata  = 64'h100 + (rd_addr >> 3);
        axi.rresp  = (rd_addr >> 3) == 64'(slverr_idx) ? 2'b10 : 2'b00;
        axi.awready = axi.awvalid && aw_wait >= aw_delay;
        aw_wait = (axi.awvalid && !axi.awready) ? aw_wait + 1 : 0;
        if (axi.awvalid && axi.awready) begin
          aw_cnt++;
          chk("aw_addr", axi.awaddr, aw_q.size() != 0 ? aw_q.pop_front() : 64'hdead);
        end
        axi.wready = axi.wvalid && w_wait >= w_delay;
        w_wait = (axi.wvalid && !axi.wready) ? w_wait + 1 : 0;
        if (axi.wvalid && axi.wready) begin
          w_cnt++;
          chk("w_data", axi.wdata, 64'h0);
          chk("w_strb", 64'(axi.wstrb), 64'hff);
        end
        axi.bvalid = axi.bready;
        axi.bresp  = 2'b00;
        if (axi.bvalid) b_cyc = cyc;
        if (out_valid_o && int'(out_idx_o) == blk_idx && blk_cnt < blk_len) begin
          out_ready_i = 0;
          if (blk_cnt > 0) begin
            chk("hold_data", out_data_o, held_data);
            chk("hold_idx", 64'(out_idx_o), 64'(held_idx));
            chk("hold_no_ar", 64'(axi.arvalid), 64'h0);
          end
          held_data = out_data_o;
          held_idx = out_idx_o;
          blk_cnt++;
        end else out_ready_i = 1;
        if (out_valid_o && out_ready_i) begin
          if (sb_q.size() == 0) exp_b = '1;
          else exp_b = sb_q.pop_front();
          chk("out_idx", 64'(out_idx_o), 64'(exp_b.idx));
          chk("out_data", out_data_o, exp_b.data);
          hs_cyc = cyc;
        end
      end
    end
  end

  task automatic scan(input logic c, input logic [7:0] f, input logic [7:0] l, input bit poke);
    int d0;
    if (f <= l)
      for (int i = int'(f); i <= int'(l); i++) begin
        sb_q.push_back({8'(i), 64'h100 + 64'(i)});
        ar_q.push_back(64'(i) * 8);
        if (c) aw_q.push_back(64'(i) * 8);
      end
    d0 = done_cnt;
    @(negedge noc_clk); #1;
    start_i = 1; clear_i = c; first_idx_i = f; last_idx_i = l; start_cyc = cyc;
    @(negedge noc_clk); #1;
    start_i = 0;
    chk("busy_start", 64'(busy_o), 64'h1);
    if (poke) begin
      start_i = 1; clear_i = 1; first_idx_i = 8'd3; last_idx_i = 8'd1;
      @(negedge noc_clk); #1;
      start_i = 0;
    end
    for (int k = 0; k < 300 && done_cnt == d0; k++) begin
      @(negedge noc_clk); #1;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'h1);
    @(negedge noc_clk); #1;
    chk("done_1cyc", 64'(done_cnt - d0), 64'h1);
    chk("busy_end", 64'(busy_o), 64'h0);
    chk("sb_empty", 64'(sb_q.size()), 64'h0);
  endtask

  initial begin
    #2 rst = 0;
    #2;
    chk("rst_ctl", 64'({busy_o, done_o, err_o, out_valid_o, axi.arvalid, axi.rready,
                        axi.awvalid, axi.wvalid, axi.bready}), 64'h0);
    chk("rst_data", out_data_o, 64'h0);
    chk("rst_idx", 64'(out_idx_o), 64'h0);
    chk("rst_addr", axi.araddr, 64'h0);
    repeat (2) @(negedge noc_clk);
    #1 rst = 1;

    a0 = ar_cnt; w0 = aw_cnt;
    scan(0, 8'd0, 8'd2, 0);
    chk("t1_ars", 64'(ar_cnt - a0), 64'd3);
    chk("t1_aws", 64'(aw_cnt - w0), 64'd0);
    chk("t1_done_lat", 64'(done_cyc - hs_cyc), 64'd1);
    chk("t1_err", 64'(err_o), 64'h0);

    blk_idx = 1; blk_len = 5; blk_cnt = 0;
    scan(0, 8'd0, 8'd2, 0);
    chk("t2_blk", 64'(blk_cnt), 64'd5);
    blk_len = 0; blk_idx = -1;

    aw_delay = 1; w_delay = 2; a0 = aw_cnt; w0 = w_cnt;
    scan(1, 8'd23, 8'd23, 0);
    chk("t3_aw", 64'(aw_cnt - a0), 64'd1);
    chk("t3_w", 64'(w_cnt - w0), 64'd1);
    chk("t3_b_done", 64'(done_cyc - b_cyc), 64'd1);
    chk("t3_err", 64'(err_o), 64'h0);
    aw_delay = 0; w_delay = 0;

    slverr_idx = 4;
    scan(0, 8'd3, 8'd5, 0);
    chk("t4_err", 64'(err_o), 64'h1);
    slverr_idx = -1;
    scan(0, 8'd0, 8'd0, 0);
    chk("t4_clr", 64'(err_o), 64'h0);

    v0 = arv_cyc + awv_cyc;
    scan(0, 8'd5, 8'd2, 0);
    chk("t5_noaxi", 64'(arv_cyc + awv_cyc - v0), 64'd0);
    chk("t5_lat", 64'((done_cyc - start_cyc) <= 2), 64'h1);
    chk("t5_err", 64'(err_o), 64'h1);

    ar_delay = 1000;
    @(negedge noc_clk); #1;
    start_i = 1; clear_i = 0; first_idx_i = 8'd9; last_idx_i = 8'd9;
    @(negedge noc_clk); #1;
    start_i = 0;
    for (int k = 0; k < 20 && !axi.arvalid; k++) begin
      @(negedge noc_clk); #1;
    end
    chk("t6_arv", 64'(axi.arvalid), 64'h1);
    #2 rst = 0;
    #1;
    chk("t6_rst_ctl", 64'({busy_o, done_o, err_o, out_valid_o, axi.arvalid, axi.rready,
                           axi.awvalid, axi.wvalid, axi.bready}), 64'h0);
    chk("t6_rst_data", out_data_o, 64'h0);
    @(negedge noc_clk); #1;
    rst = 1; ar_delay = 0;
    sb_q.delete(); ar_q.delete(); aw_q.delete();
    a0 = ar_cnt; w0 = aw_cnt;
    scan(0, 8'd7, 8'd8, 1);
    chk("t6_ars", 64'(ar_cnt - a0), 64'd2);
    chk("t6_aws", 64'(aw_cnt - w0), 64'd0);
    chk("t6_err", 64'(err_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
